// File: rtl/serial_magnitude.sv
// serial_magnitude: bit-serial two's-complement to sign-magnitude converter (LSB-first copy-then-invert rule).
// Optional feature macro SERIAL_MAGNITUDE_SATURATE_EN clamps the most-negative input to 2^(N-1)-1 and flags overflow.
module serial_magnitude #(
  parameter int N = 8
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         start_i,
  input  logic [N-1:0] number_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         sign_o,
  output logic [N-1:0] magnitude_o,
  output logic         overflow_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef SERIAL_MAGNITUDE_SATURATE_EN
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_POS  = {1'b0, {(N-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  work_q;
  logic [CW-1:0] cnt_q;
  logic          seen_one_q;
  logic          sign_flag_q;
  logic          busy_q;
  logic          done_q;
  logic          sign_q;
  logic [N-1:0]  magnitude_q;
  logic          overflow_q;

  logic          out_bit_d;
  logic [N-1:0]  work_d;
  logic [N-1:0]  mag_d;
  logic          ovf_d;

  // Serial bit rule plus the magnitude/overflow that would be committed on the final shift.
  always_comb begin
    out_bit_d = shift_q[0];
    if (sign_flag_q && seen_one_q) begin
      out_bit_d = ~shift_q[0];
    end else begin
      out_bit_d = shift_q[0];
    end
    work_d = {out_bit_d, work_q[N-1:1]};
    mag_d  = work_d;
    ovf_d  = 1'b0;
`ifdef SERIAL_MAGNITUDE_SATURATE_EN
    if (sign_flag_q && (work_d == MOST_NEG)) begin
      mag_d = MAX_POS;
      ovf_d = 1'b1;
    end else begin
      mag_d = work_d;
      ovf_d = 1'b0;
    end
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      seen_one_q  <= 1'b0;
      sign_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sign_q      <= 1'b0;
      magnitude_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            shift_q     <= number_i;
            work_q      <= '0;
            sign_flag_q <= number_i[N-1];
            cnt_q       <= '0;
            seen_one_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          shift_q    <= {1'b0, shift_q[N-1:1]};
          work_q     <= work_d;
          seen_one_q <= seen_one_q | shift_q[0];
          if (cnt_q == CNT_LAST) begin
            // Results are only ever updated here, so they hold through IDLE.
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            sign_q      <= sign_flag_q;
            magnitude_q <= mag_d;
            overflow_q  <= ovf_d;
            state_q     <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= S_SHIFT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sign_o      = sign_q;
  assign magnitude_o = magnitude_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_magnitude.sv
// Self-checking bench for serial_magnitude: vector table, hand sequences for corner cases, randomized reference-model run.
module tb_serial_magnitude;

  localparam int N = 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [N-1:0] number;
  logic         busy;
  logic         done;
  logic         sign;
  logic [N-1:0] magnitude;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  serial_magnitude #(.N(N)) dut (
    .clock_i    (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .number_i   (number),
    .busy_o     (busy),
    .done_o     (done),
    .sign_o     (sign),
    .magnitude_o(magnitude),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] num;
    logic       exp_sign;
    logic [7:0] exp_mag;
    logic       exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: absolute value by plain integer arithmetic.
  function automatic void ref_model(input logic [7:0] n, output logic s, output logic [7:0] m, output logic o);
    int v;
    v = $signed(n);
    s = (v < 0);
    if (v < 0) v = -v;
    o = 1'b0;
`ifdef SERIAL_MAGNITUDE_SATURATE_EN
    if (v == 128) begin
      v = 127;
      o = 1'b1;
    end
`endif
    m = v[7:0];
  endfunction

  // Start a conversion, scramble number afterwards, check timing and results.
  task automatic do_conv(input string tag, input logic [7:0] num,
                         input logic es, input logic [7:0] em, input logic eo);
    int k;
    int busy_cnt;
    @(negedge clk);
    start  = 1'b1;
    number = num;
    @(negedge clk);
    start  = 1'b0;
    number = 8'($urandom);
    k = 1;
    busy_cnt = 0;
    while (!done && k <= 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, N + 1);
    check({tag, " busy_cycles"}, busy_cnt, N);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " sign"}, {31'd0, sign}, {31'd0, es});
    check({tag, " magnitude"}, {24'd0, magnitude}, {24'd0, em});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    logic       rs;
    logic [7:0] rm;
    logic       ro;
    logic [7:0] rn;
    int         k;
    int         dcount;
    int         first_done;
    int         second_done;

    vecs[0] = '{8'h05, 1'b0, 8'h05, 1'b0};
    vecs[1] = '{8'hFB, 1'b1, 8'h05, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 8'h01, 1'b0};
`ifdef SERIAL_MAGNITUDE_SATURATE_EN
    vecs[4] = '{8'h80, 1'b1, 8'h7F, 1'b1};
`else
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0};
`endif
    vecs[5] = '{8'h7F, 1'b0, 8'h7F, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 8'h7F, 1'b0};
    vecs[7] = '{8'hA4, 1'b1, 8'h5C, 1'b0};
    vecs[8] = '{8'h01, 1'b0, 8'h01, 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    number  = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset sign", {31'd0, sign}, 32'd0);
    check("reset magnitude", {24'd0, magnitude}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    check("idle busy", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_conv($sformatf("vec%0d", i), vecs[i].num, vecs[i].exp_sign, vecs[i].exp_mag, vecs[i].exp_ovf);
    end

    // Request during SHIFT is dropped; results hold afterwards.
    @(negedge clk);
    start  = 1'b1;
    number = 8'h0C;
    @(negedge clk);
    start  = 1'b0;
    k = 1;
    dcount = 0;
    while (k <= 30) begin
      if (k == 3) begin
        start  = 1'b1;
        number = 8'h30;
      end else begin
        start  = 1'b0;
      end
      if (done) begin
        dcount++;
        check("ignored_start magnitude", {24'd0, magnitude}, 32'h0C);
        check("ignored_start sign", {31'd0, sign}, 32'd0);
      end
      @(negedge clk);
      k++;
    end
    check("ignored_start done_count", dcount, 1);
    check("ignored_start hold", {23'd0, busy, magnitude}, 32'h0C);

    // Held start: back-to-back conversions spaced N+2 cycles.
    @(negedge clk);
    start  = 1'b1;
    number = 8'hFD;
    k = 0;
    first_done = -1;
    second_done = -1;
    while (second_done < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (done && first_done < 0) first_done = k;
      else if (done) begin
        second_done = k;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b spacing", second_done - first_done, N + 2);
    check("b2b magnitude", {23'd0, sign, magnitude}, 32'h103);
    repeat (12) @(negedge clk);
    check("b2b no_third", {30'd0, busy, done}, 32'd0);

    // Reset mid-conversion aborts without done.
    @(negedge clk);
    start  = 1'b1;
    number = 8'hF0;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort outputs", {22'd0, done, sign, overflow, magnitude}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    check("abort no_activity", dcount, 0);
    do_conv("after_abort", 8'h10, 1'b0, 8'h10, 1'b0);

    // Randomized run against the reference model.
    for (int i = 0; i < 40; i++) begin
      rn = 8'($urandom);
      if (i == 0) rn = 8'h80;
      ref_model(rn, rs, rm, ro);
      do_conv($sformatf("rand%0d_%02h", i, rn), rn, rs, rm, ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_magnitude.md
# serial_magnitude

Bit-serial converter from an N-bit two's-complement number to sign-magnitude form: a sign bit plus an N-bit unsigned magnitude. It is the decoding counterpart of the datapath's two's-complement negation. It sits beside the register file's arithmetic path, where a multi-cycle, area-cheap conversion is preferred over a parallel N-bit adder. It uses the serial rule: scan LSB-first, copy bits up to and including the first 1, then invert the remaining bits.

## Interface
- N, 8, width of the input number and of the output magnitude (N ≥ 2)
- clock  in  1  single system clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request a conversion; sampled only in IDLE
- number  in  N  two's-complement operand; captured on the accepted start edge
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse; sign/magnitude/overflow valid from this cycle
- sign  out  1  sign of the last converted number (1 = negative)
- magnitude  out  N  unsigned absolute value of the last converted number
- overflow  out  1  magnitude could not be represented (see Configuration)

## Operation
- FSM with three states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch number into the shift register
  - set internal sign flag = number[N-1], bit counter = 0, seen_one = 0
  - go to SHIFT
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle, processing bit b = shift_reg[0]:
  - out_bit = b if sign flag = 0 or seen_one = 0, else ~b
  - seen_one |= b
  - shift out_bit into the MSB of a working register (right shift), so bit 0 lands in position 0 after N shifts
  - counter increments; when counter = N-1, go to DONE
- SHIFT → DONE transition:
  - copy working register to magnitude and sign flag to sign
  - set overflow per Configuration
  - assert done
- DONE: lasts exactly one cycle, then go to IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing; a request is lost if it is not held until IDLE.
- sign, magnitude and overflow change only on the SHIFT→DONE edge. They hold their values through IDLE until the next completion.
- Changes on number after the start edge do not affect the conversion.
- Zero input: seen_one stays 0, so magnitude = 0 and sign = 0.

## Timing
- Reset (reset_n = 0 at a rising edge):
  - state IDLE
  - busy = 0, done = 0, sign = 0, magnitude = 0, overflow = 0
  - counter, seen_one and shift/working registers cleared
- Reset takes priority over all other inputs. A reset during SHIFT aborts the conversion with no done pulse, and the outputs return to 0.
- Accepted start at edge E:
  - busy = 1 from after E through the cycle after edge E+N-1
  - done = 1 for exactly the cycle after edge E+N
  - busy = 0 while done = 1
- Latency from start edge to done: N cycles. Minimum start-to-start spacing: N+2 cycles, since start is accepted again in the cycle after done.
- done and busy are registered outputs; no combinational path from any input to any output.

## Configuration
- Macro: SERIAL_MAGNITUDE_SATURATE_EN.
- Undefined (default), most-negative input 2^(N-1) (e.g. 0x80 for N=8):
  - magnitude = 2^(N-1) (0x80), the natural serial result
  - sign = 1
  - overflow is tied to 0
- Defined, same input:
  - magnitude saturates to 2^(N-1)-1 (0x7F for N=8)
  - sign = 1, overflow = 1 together with done
  - all other inputs give overflow = 0
  - intended for consumers that treat the magnitude as a signed N-bit value

## Test plan
- N=8, reset_n=0 for 2 cycles, then release → all outputs 0, busy=0, start=0 keeps IDLE.
- number=0x05, start pulse → busy for 8 cycles, done 8 cycles after start, sign=0, magnitude=0x05, overflow=0. Repeat with number=0xFB → sign=1, magnitude=0x05.
- number=0x00 → sign=0, magnitude=0x00. Then number=0xFF → sign=1, magnitude=0x01.
- number=0x80 → without macro: sign=1, magnitude=0x80, overflow=0. With SERIAL_MAGNITUDE_SATURATE_EN: magnitude=0x7F, overflow=1.
- start with 0x0C, then start with 0x30 and number change at cycle 3 → second request ignored. done once with magnitude=0x0C; outputs hold until the next accepted start completes.
- start with 0xF0, reset_n=0 at cycle 4 → no done, busy=0 and magnitude=0 after the reset edge. A fresh start with 0x10 gives magnitude=0x10 after 8 cycles.
